// File: rtl/lcd_seq_addr_gen_if.sv
// lcd_seq_addr_gen_if: ROM address handshake between the LCD address
// sequencer (master) and the ROM / pixel path (slave).
//   addr_valid  master -> slave  addr is meaningful
//   addr        master -> slave  ROM address
//   addr_ready  slave  -> master consumer accepts the current addr
interface lcd_seq_addr_gen_if #(
  parameter int unsigned ADDR_WIDTH = 17
);
  logic                  addr_valid;
  logic                  addr_ready;
  logic [ADDR_WIDTH-1:0] addr;

  modport master (
    output addr_valid,
    output addr,
    input  addr_ready
  );

  modport slave (
    input  addr_valid,
    input  addr,
    output addr_ready
  );
endinterface

// File: rtl/lcd_seq_addr_gen.sv
// lcd_seq_addr_gen: address sequencer for the LCD command/pixel ROM path.
// Walks a compile-time table of NUM_SEG segments. Each segment ramps the
// address from SEG_START[i] to SEG_END[i], then holds SEG_END[i] for
// SEG_HOLD[i] extra beats. A beat is addr_valid & en & addr_ready; nothing
// advances without one. LOOP=1 restarts at segment 0 after the last segment.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      pulse, launches the sequence from IDLE or DONE
//   abort      synchronous return to IDLE (priority over start and beats)
//   en         global advance enable
//   bus        lcd_seq_addr_gen_if.master: addr_valid, addr, addr_ready
//   seg_idx    active segment index
//   seg_done   one-cycle pulse after the final beat of a segment
//   seq_done   one-cycle pulse after the final beat of the last segment
//   busy       high in RAMP/HOLD
//   mark       per-segment marker pulses
//
// Optional feature macro: LCD_SEQ_MARK_EN. When defined, mark[i] pulses the
// cycle after a ramp beat on addr==SEG_MARK[i] while seg_idx==i. When not
// defined, mark is tied to 0 and SEG_MARK is ignored.
module lcd_seq_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned NUM_SEG    = 2,
  parameter int unsigned HOLD_WIDTH = 16,
  parameter logic [NUM_SEG*ADDR_WIDTH-1:0] SEG_START = {17'd10, 17'd4},
  parameter logic [NUM_SEG*ADDR_WIDTH-1:0] SEG_END   = {17'd11, 17'd6},
  parameter logic [NUM_SEG*HOLD_WIDTH-1:0] SEG_HOLD  = {16'd0, 16'd2},
  parameter logic [NUM_SEG*ADDR_WIDTH-1:0] SEG_MARK  = {17'd11, 17'd5},
  parameter bit LOOP = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       en,
  lcd_seq_addr_gen_if.master         bus,
  output logic [$clog2(NUM_SEG):0]   seg_idx,
  output logic                       seg_done,
  output logic                       seq_done,
  output logic                       busy,
  output logic [NUM_SEG-1:0]         mark
);

  localparam int unsigned IDXW = $clog2(NUM_SEG) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RAMP, S_HOLD, S_DONE} state_t;

  // Table sanity: every segment must ramp upwards (or be a single address).
  if (NUM_SEG < 1 || NUM_SEG > 16) begin : g_bad_num_seg
    $error("lcd_seq_addr_gen: NUM_SEG must be 1..16");
  end
  for (genvar g = 0; g < NUM_SEG; g++) begin : g_tbl_chk
    if (SEG_END[g*ADDR_WIDTH +: ADDR_WIDTH] < SEG_START[g*ADDR_WIDTH +: ADDR_WIDTH]) begin : g_bad
      $error("lcd_seq_addr_gen: segment %0d has SEG_END below SEG_START", g);
    end
  end
`ifndef LCD_SEQ_MARK_EN
  if ($bits(SEG_MARK) != NUM_SEG*ADDR_WIDTH) begin : g_bad_mark
    $error("lcd_seq_addr_gen: SEG_MARK width mismatch");
  end
`endif

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt;
  logic [IDXW-1:0]         idx_q, idx_nxt;
  logic [HOLD_WIDTH-1:0]   hold_q, hold_nxt;
  logic                    valid_q, valid_nxt;
  logic                    busy_q, busy_nxt;
  logic                    seg_done_q, seg_done_nxt;
  logic                    seq_done_q, seq_done_nxt;
  logic [NUM_SEG-1:0]      mark_q, mark_nxt;
  logic                    beat;
  logic                    seg_end;
  logic                    last_seg;
  logic [ADDR_WIDTH-1:0]   cur_end;
  logic [HOLD_WIDTH-1:0]   cur_hold;

  // Table lookups are written as explicit muxes so an index past the table
  // can never produce an out-of-range select.
  function automatic logic [ADDR_WIDTH-1:0] tbl_start(input logic [IDXW-1:0] i);
    tbl_start = '0;
    for (int unsigned s = 0; s < NUM_SEG; s++)
      if (i == IDXW'(s)) tbl_start = SEG_START[s*ADDR_WIDTH +: ADDR_WIDTH];
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] tbl_end(input logic [IDXW-1:0] i);
    tbl_end = '0;
    for (int unsigned s = 0; s < NUM_SEG; s++)
      if (i == IDXW'(s)) tbl_end = SEG_END[s*ADDR_WIDTH +: ADDR_WIDTH];
  endfunction

  function automatic logic [HOLD_WIDTH-1:0] tbl_hold(input logic [IDXW-1:0] i);
    tbl_hold = '0;
    for (int unsigned s = 0; s < NUM_SEG; s++)
      if (i == IDXW'(s)) tbl_hold = SEG_HOLD[s*HOLD_WIDTH +: HOLD_WIDTH];
  endfunction

  assign beat     = valid_q & en & bus.addr_ready;
  assign last_seg = (idx_q == IDXW'(NUM_SEG - 1));
  assign cur_end  = tbl_end(idx_q);
  assign cur_hold = tbl_hold(idx_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr_q     <= tbl_start('0);
      idx_q      <= '0;
      hold_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      seg_done_q <= 1'b0;
      seq_done_q <= 1'b0;
      mark_q     <= '0;
    end else begin
      state      <= state_nxt;
      addr_q     <= addr_nxt;
      idx_q      <= idx_nxt;
      hold_q     <= hold_nxt;
      valid_q    <= valid_nxt;
      busy_q     <= busy_nxt;
      seg_done_q <= seg_done_nxt;
      seq_done_q <= seq_done_nxt;
      mark_q     <= mark_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr_q;
    idx_nxt      = idx_q;
    hold_nxt     = hold_q;
    valid_nxt    = valid_q;
    busy_nxt     = busy_q;
    seg_done_nxt = 1'b0;
    seq_done_nxt = 1'b0;
    mark_nxt     = '0;
    seg_end      = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_RAMP;
          addr_nxt  = tbl_start('0);
          idx_nxt   = '0;
          hold_nxt  = '0;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      S_RAMP: begin
        if (beat) begin
          if (addr_q < cur_end) begin
            addr_nxt = addr_q + 1'b1;
          end else if (cur_hold != '0) begin
            state_nxt = S_HOLD;
            hold_nxt  = cur_hold - 1'b1;
          end else begin
            seg_end = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (beat) begin
          if (hold_q != '0) hold_nxt = hold_q - 1'b1;
          else              seg_end  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // The next segment's first address is loaded on the same edge that
    // retires the current one, so the consumer sees no gap cycle.
    if (seg_end) begin
      seg_done_nxt = 1'b1;
      hold_nxt     = '0;
      if (!last_seg) begin
        idx_nxt   = idx_q + 1'b1;
        addr_nxt  = tbl_start(idx_q + 1'b1);
        state_nxt = S_RAMP;
      end else begin
        seq_done_nxt = 1'b1;
        if (LOOP) begin
          idx_nxt   = '0;
          addr_nxt  = tbl_start('0);
          state_nxt = S_RAMP;
        end else begin
          state_nxt = S_DONE;
          valid_nxt = 1'b0;
          busy_nxt  = 1'b0;
        end
      end
    end

`ifdef LCD_SEQ_MARK_EN
    // Only ramp beats qualify, so a hold parked on the marker address
    // produces a single pulse.
    if (beat && state == S_RAMP) begin
      for (int unsigned s = 0; s < NUM_SEG; s++)
        if (idx_q == IDXW'(s) && addr_q == SEG_MARK[s*ADDR_WIDTH +: ADDR_WIDTH])
          mark_nxt[s] = 1'b1;
    end
`endif

    if (abort) begin
      state_nxt    = S_IDLE;
      addr_nxt     = addr_q;
      idx_nxt      = idx_q;
      hold_nxt     = '0;
      valid_nxt    = 1'b0;
      busy_nxt     = 1'b0;
      seg_done_nxt = 1'b0;
      seq_done_nxt = 1'b0;
      mark_nxt     = '0;
    end
  end

  assign bus.addr_valid = valid_q;
  assign bus.addr       = addr_q;
  assign seg_idx        = idx_q;
  assign seg_done       = seg_done_q;
  assign seq_done       = seq_done_q;
  assign busy           = busy_q;
  assign mark           = mark_q;

endmodule

// File: tb/tb_lcd_seq_addr_gen.sv
// tb_lcd_seq_addr_gen: scoreboard bench for lcd_seq_addr_gen. Two instances
// share all inputs: dut_a runs one-shot (LOOP=0), dut_b free-running (LOOP=1).
// The stimulus process pushes the expected beat list of a whole pass when a
// start is accepted; a negedge monitor pops one entry per beat and checks
// address, index, handshake and the pulses that follow each beat.
module tb_lcd_seq_addr_gen;

  localparam int AW = 17;
  localparam int NS = 2;
  localparam int HW = 16;

  localparam logic [NS*AW-1:0] P_START = {17'd10, 17'd4};
  localparam logic [NS*AW-1:0] P_END   = {17'd11, 17'd6};
  localparam logic [NS*HW-1:0] P_HOLD  = {16'd0, 16'd2};
  localparam logic [NS*AW-1:0] P_MARK  = {17'd11, 17'd5};

  // Reference table in plain integers.
  int T_START [NS] = '{4, 10};
  int T_END   [NS] = '{6, 11};
  int T_HOLD  [NS] = '{2, 0};
  int T_MARK  [NS] = '{5, 11};
  bit T_LOOP  [2]  = '{1'b0, 1'b1};

  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    seg;
    bit            last_seg;
    bit            last_seq;
    logic [NS-1:0] mark;
  } exp_t;

  logic clk, rst, start, abort, en, addr_ready;

  lcd_seq_addr_gen_if #(.ADDR_WIDTH(AW)) if_a ();
  lcd_seq_addr_gen_if #(.ADDR_WIDTH(AW)) if_b ();
  assign if_a.addr_ready = addr_ready;
  assign if_b.addr_ready = addr_ready;

  logic [1:0]    idx_a, idx_b;
  logic          sgd_a, sgd_b, sqd_a, sqd_b, busy_a, busy_b;
  logic [NS-1:0] mark_a, mark_b;

  lcd_seq_addr_gen #(
    .ADDR_WIDTH(AW), .NUM_SEG(NS), .HOLD_WIDTH(HW),
    .SEG_START(P_START), .SEG_END(P_END), .SEG_HOLD(P_HOLD), .SEG_MARK(P_MARK),
    .LOOP(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .en(en),
    .bus(if_a.master), .seg_idx(idx_a), .seg_done(sgd_a), .seq_done(sqd_a),
    .busy(busy_a), .mark(mark_a)
  );

  lcd_seq_addr_gen #(
    .ADDR_WIDTH(AW), .NUM_SEG(NS), .HOLD_WIDTH(HW),
    .SEG_START(P_START), .SEG_END(P_END), .SEG_HOLD(P_HOLD), .SEG_MARK(P_MARK),
    .LOOP(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .en(en),
    .bus(if_b.master), .seg_idx(idx_b), .seg_done(sgd_b), .seq_done(sqd_b),
    .busy(busy_b), .mark(mark_b)
  );

  logic          m_valid [2];
  logic [AW-1:0] m_addr  [2];
  logic [1:0]    m_idx   [2];
  logic          m_sgd   [2];
  logic          m_sqd   [2];
  logic          m_busy  [2];
  logic [NS-1:0] m_mark  [2];
  assign m_valid[0] = if_a.addr_valid;  assign m_valid[1] = if_b.addr_valid;
  assign m_addr[0]  = if_a.addr;        assign m_addr[1]  = if_b.addr;
  assign m_idx[0]   = idx_a;            assign m_idx[1]   = idx_b;
  assign m_sgd[0]   = sgd_a;            assign m_sgd[1]   = sgd_b;
  assign m_sqd[0]   = sqd_a;            assign m_sqd[1]   = sqd_b;
  assign m_busy[0]  = busy_a;           assign m_busy[1]  = busy_b;
  assign m_mark[0]  = mark_a;           assign m_mark[1]  = mark_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q [2][$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   loop_running = 1'b0;

  // One full pass of the sequence, derived from the table rules.
  task automatic push_pass(input int k);
    exp_t e;
    for (int i = 0; i < NS; i++) begin
      for (int a = T_START[i]; a <= T_END[i]; a++) begin
        e.addr     = AW'(a);
        e.seg      = 2'(i);
        e.last_seg = (a == T_END[i]) && (T_HOLD[i] == 0);
        e.last_seq = e.last_seg && (i == NS - 1);
        e.mark     = '0;
`ifdef LCD_SEQ_MARK_EN
        if (a == T_MARK[i]) e.mark[i] = 1'b1;
`endif
        exp_q[k].push_back(e);
      end
      for (int h = 0; h < T_HOLD[i]; h++) begin
        e.addr     = AW'(T_END[i]);
        e.seg      = 2'(i);
        e.last_seg = (h == T_HOLD[i] - 1);
        e.last_seq = e.last_seg && (i == NS - 1);
        e.mark     = '0;
        exp_q[k].push_back(e);
      end
    end
  endtask

  // One clock of stimulus: drive inputs, let the edge sample them, then
  // record what the reference says the edge started.
  task automatic cycle(input bit s, input bit a, input bit r, input bit e, input bit rd);
    bit acc [2];
    start = s; abort = a; rst = r; en = e; addr_ready = rd;
    for (int k = 0; k < 2; k++) acc[k] = s && !a && !r && (exp_q[k].size() == 0);
    if (a || r) loop_running = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) if (acc[k]) push_pass(k);
    if (acc[1]) loop_running = 1'b1;
    if (loop_running && exp_q[1].size() < 8) push_pass(1);
  endtask

  task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL dut%0d %s: got %0h, expected %0h (t=%0t)", k, name, got, want, $time);
    end
  endtask

  // Monitor state.
  bit            armed = 1'b0;
  bit            pend_seg [2] = '{1'b0, 1'b0};
  bit            pend_seq [2] = '{1'b0, 1'b0};
  logic [NS-1:0] pend_mark [2] = '{'0, '0};
  bit            idle_known [2] = '{1'b0, 1'b0};
  logic [AW-1:0] idle_addr [2];
  bit            idle_idx_known [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin : mon
      bit   act;
      bit   bt;
      exp_t e;
      act = (exp_q[k].size() != 0);
      if (armed) begin
        check("addr_valid", k, 32'(m_valid[k]), 32'(act));
        check("busy",       k, 32'(m_busy[k]),  32'(act));
        check("seg_done",   k, 32'(m_sgd[k]),   32'(pend_seg[k]));
        check("seq_done",   k, 32'(m_sqd[k]),   32'(pend_seq[k]));
`ifdef LCD_SEQ_MARK_EN
        check("mark",       k, 32'(m_mark[k]),  32'(pend_mark[k]));
`else
        check("mark",       k, 32'(m_mark[k]),  32'(0));
`endif
        if (act) begin
          check("addr",    k, 32'(m_addr[k]), 32'(exp_q[k][0].addr));
          check("seg_idx", k, 32'(m_idx[k]),  32'(exp_q[k][0].seg));
        end else begin
          if (idle_known[k])     check("idle_addr", k, 32'(m_addr[k]), 32'(idle_addr[k]));
          if (idle_idx_known[k]) check("idle_idx",  k, 32'(m_idx[k]),  32'(0));
        end
      end
      bt = act && en && addr_ready && !abort && !rst;
      pend_seg[k]  = 1'b0;
      pend_seq[k]  = 1'b0;
      pend_mark[k] = '0;
      if (rst) begin
        exp_q[k].delete();
        idle_known[k]     = 1'b1;
        idle_addr[k]      = AW'(T_START[0]);
        idle_idx_known[k] = 1'b1;
      end else if (abort) begin
        exp_q[k].delete();
        idle_known[k]     = 1'b0;
        idle_idx_known[k] = 1'b0;
      end else if (bt) begin
        e = exp_q[k].pop_front();
        pend_seg[k]  = e.last_seg;
        pend_seq[k]  = e.last_seq;
        pend_mark[k] = e.mark;
        if (e.last_seq && !T_LOOP[k]) begin
          idle_known[k]     = 1'b1;
          idle_addr[k]      = e.addr;
          idle_idx_known[k] = 1'b0;
        end
      end
    end
    if (rst) armed = 1'b1;
  end

  initial begin
    start = 1'b0; abort = 1'b0; rst = 1'b1; en = 1'b1; addr_ready = 1'b1;
    // Reset and idle.
    cycle(0, 0, 1, 1, 1);
    cycle(0, 0, 1, 1, 1);
    repeat (3) cycle(0, 0, 0, 1, 1);
    // Free-flowing pass; dut_a ends parked on address 11.
    cycle(1, 0, 0, 1, 1);
    repeat (12) cycle(0, 0, 0, 1, 1);
    // Ready low for three cycles during the ramp.
    cycle(0, 0, 1, 1, 1);
    cycle(1, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    repeat (3) cycle(0, 0, 0, 1, 0);
    repeat (10) cycle(0, 0, 0, 1, 1);
    // Abort in the hold at address 6, then restart.
    cycle(0, 0, 1, 1, 1);
    cycle(1, 0, 0, 1, 1);
    repeat (3) cycle(0, 0, 0, 1, 1);
    cycle(0, 1, 0, 1, 1);
    repeat (2) cycle(0, 0, 0, 1, 1);
    cycle(1, 0, 0, 1, 1);
    repeat (10) cycle(0, 0, 0, 1, 1);
    // Start while busy, then reset mid-ramp.
    cycle(0, 0, 1, 1, 1);
    cycle(1, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(1, 0, 0, 1, 1);
    cycle(0, 0, 1, 1, 1);
    repeat (3) cycle(0, 0, 0, 1, 1);
    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      int r;
      bit s, a, rs;
      r  = int'($urandom_range(0, 199));
      rs = (r < 2);
      a  = !rs && (r < 6);
      s  = !rs && !a && (r < 30);
      cycle(s, a, rs, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7);
    end
    cycle(0, 0, 1, 1, 1);
    repeat (2) cycle(0, 0, 0, 1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_seq_addr_gen.md
Name: lcd_seq_addr_gen

Overview:
- Parametrised address sequencer for the LCD command/pixel ROM path.
- Walks a compile-time table of NUM_SEG segments. Each segment ramps an address from a start value to an end value, then holds the end address for a programmable number of beats, typically used as a delay or clear fill.
- Drives the ROM address with a valid/ready handshake. Flags segment and sequence completion.
- Supports one-shot or free-running loop mode.

Parameters:
- ADDR_WIDTH, 17, width of addr.
- NUM_SEG, 2, number of segments (1..16).
- HOLD_WIDTH, 16, width of the per-segment hold counter.
- SEG_START, packed NUM_SEG*ADDR_WIDTH, start address of segment i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- SEG_END, packed NUM_SEG*ADDR_WIDTH, end address of segment i; must satisfy SEG_END[i] >= SEG_START[i].
- SEG_HOLD, packed NUM_SEG*HOLD_WIDTH, extra beats at SEG_END[i] after the ramp; 0 means no hold.
- SEG_MARK, packed NUM_SEG*ADDR_WIDTH, marker address per segment; used only with LCD_SEQ_MARK_EN.
- LOOP, 1, 1 = restart at segment 0 after the last segment; 0 = stop.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  pulse; launches the sequence from IDLE or DONE.
- abort  in  1  synchronous abort to IDLE.
- en  in  1  global advance enable.
- addr_ready  in  1  consumer accepts the current addr.
- addr_valid  out  1  addr is meaningful.
- addr  out  ADDR_WIDTH  current ROM address.
- seg_idx  out  $clog2(NUM_SEG)+1  index of the active segment.
- seg_done  out  1  one-cycle pulse: a segment completed.
- seq_done  out  1  one-cycle pulse: last segment completed.
- busy  out  1  high in RAMP/HOLD.
- mark  out  NUM_SEG  per-segment marker pulses; tied 0 unless LCD_SEQ_MARK_EN.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, addr=SEG_START[0], seg_idx=0, addr_valid=0, busy=0, seg_done=0, seq_done=0, mark=0, hold_cnt=0.
- Beat definition: beat = addr_valid & en & addr_ready. Nothing advances without a beat; en=0 or addr_ready=0 freezes all state.
- States:
  - IDLE: addr_valid=0. On start, the next cycle enters RAMP with addr=SEG_START[0], seg_idx=0, addr_valid=1, busy=1.
  - RAMP: on a beat, if addr<SEG_END[seg_idx] then addr+1.
    - If addr==SEG_END and SEG_HOLD!=0: enter HOLD with hold_cnt=SEG_HOLD-1; addr unchanged.
    - If addr==SEG_END and SEG_HOLD==0: the segment ends.
  - HOLD: addr held at SEG_END. On a beat, if hold_cnt!=0 then decrement; if hold_cnt==0 the segment ends.
  - DONE: addr_valid=0, busy=0, addr holds the last SEG_END. On start, behaves as from IDLE.
- Segment end, applied on the cycle after the final beat of the segment:
  - seg_done=1 for one cycle.
  - If seg_idx<NUM_SEG-1: seg_idx+1, addr=SEG_START[next], state RAMP. The next segment's first address is presented with no gap cycle.
  - If last segment: seq_done=1 for one cycle.
    - LOOP=1: seg_idx=0, addr=SEG_START[0], RAMP.
    - LOOP=0: DONE, addr_valid=0.
- Beats per segment: (SEG_END-SEG_START+1)+SEG_HOLD.
- Arithmetic: all ADDR_WIDTH unsigned, no wrap. A table violating SEG_END>=SEG_START triggers an elaboration-time $error.
- start while busy: ignored.
- abort: next cycle forces IDLE; pulses cleared; no seg_done/seq_done generated. abort has priority over start and beats.
- rst mid-operation: returns to reset values the next edge.
- Single-beat segment (start==end, hold 0): one beat, then seg_done.

Optional Feature:
- Macro: LCD_SEQ_MARK_EN.
- Defined: mark[i] pulses for one cycle on the cycle after a beat on which addr==SEG_MARK[i] and seg_idx==i. During a hold at the marker address, mark[i] pulses on the first such beat only.
- Undefined: mark is tied to 0; the comparators and SEG_MARK are unused.

Test Plan:
- NUM_SEG=2, seg0 {4..6, hold 2}, seg1 {10..11, hold 0}, LOOP=0, en=ready=1, start at cycle 0 -> addr 4,5,6,6,6,10,11 on cycles 1..7. seg_done in cycles 6 and 8; seq_done in cycle 8. addr_valid=0 from cycle 8; addr stays 11.
- Same table, addr_ready low on cycles 2-4 -> addr stays 5 while stalled; the sequence completes 3 cycles later; no beats are lost or duplicated.
- LOOP=1 -> after 11 the next presented addr is 4, with seq_done pulsing alongside it; sequence repeats indefinitely.
- abort asserted while in HOLD at addr 6 -> IDLE the next cycle, addr_valid=0, no seg_done; a subsequent start restarts at addr 4.
- Start pulse while busy, and rst asserted mid-RAMP -> start is ignored; rst restores reset values (addr=4, seg_idx=0, all flags 0).
- LCD_SEQ_MARK_EN defined, SEG_MARK={5,11} -> mark[0] pulses the cycle after addr 5's beat; mark[1] pulses the cycle after addr 11's beat; with the macro undefined, mark stays 0.
